// File: rtl/tl_cfg_reader.sv
// tl_cfg_reader: system-clock side of the SPI slave register file.
// Synchronises the slave's config-written flag, reads the red/green
// durations over a four-phase r_en/ren_ack handshake and runs the traffic
// light sequencer from the committed values.
// Optional build macro: TL_RD_TIMEOUT_EN (handshake timeout + sticky cfg_err).
module tl_cfg_reader #(
    parameter int unsigned TICK_DIV   = 1000,
    parameter int unsigned Y_WAIT     = 2,
    parameter int unsigned DEF_R_WAIT = 3,
    parameter int unsigned DEF_G_WAIT = 3,
    parameter int unsigned TO_CYCLES  = 1024
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       done,
    output logic       done_sync2,
    output logic       r_en,
    output logic [1:0] r_addr,
    input  logic [2:0] r_data,
    input  logic       ren_ack,
    output logic       light_r,
    output logic       light_y,
    output logic       light_g,
    output logic       cfg_busy,
    output logic       cfg_err
);

    localparam int unsigned TW = $clog2(TICK_DIV);

    if (TICK_DIV < 2 || TO_CYCLES == 0) begin : g_param_check
        $error("tl_cfg_reader: TICK_DIV must be >= 2 and TO_CYCLES >= 1");
    end

    typedef enum logic [2:0] {
        RD_IDLE,
        RD_REQ0,
        RD_REL0,
        RD_REQ1,
        RD_REL1,
        RD_COMMIT
    } rd_state_e;

    typedef enum logic [1:0] {
        LT_RED,
        LT_GREEN,
        LT_YELLOW
    } lt_state_e;

    // A programmed duration of zero still shows the lamp for one tick.
    function automatic logic [2:0] phase_len(input logic [2:0] v);
        return (v == '0) ? 3'd1 : v;
    endfunction

    logic done_s1_q, done_s2_q, done_s3_q;
    logic ack_s1_q, ack_s2_q;
    logic new_cfg;

    rd_state_e  rd_state_q;
    logic       r_en_q;
    logic [1:0] r_addr_q;
    logic       busy_q;
    logic       pending_q;
    logic [2:0] tmp_r_q, tmp_g_q;
    logic [2:0] r_wait_q, g_wait_q;

    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic          tick;

    lt_state_e  lt_state_q;
    logic [2:0] lt_cnt_q;
    logic       lamp_r_q, lamp_y_q, lamp_g_q;

    // Two-flop synchronisers plus a third done flop for edge detection.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            done_s1_q <= 1'b0;
            done_s2_q <= 1'b0;
            done_s3_q <= 1'b0;
            ack_s1_q  <= 1'b0;
            ack_s2_q  <= 1'b0;
        end else begin
            done_s1_q <= done;
            done_s2_q <= done_s1_q;
            done_s3_q <= done_s2_q;
            ack_s1_q  <= ren_ack;
            ack_s2_q  <= ack_s1_q;
        end
    end

    assign new_cfg = done_s2_q & ~done_s3_q;

`ifdef TL_RD_TIMEOUT_EN
    localparam int unsigned TO_W = $clog2(TO_CYCLES + 1);
    logic [TO_W-1:0] wait_q;
    logic            err_q;
    logic            rd_waiting;
    logic            timeout;

    assign rd_waiting = (rd_state_q == RD_REQ0) || (rd_state_q == RD_REL0) ||
                        (rd_state_q == RD_REQ1) || (rd_state_q == RD_REL1);
    assign timeout    = rd_waiting && (wait_q == TO_W'(TO_CYCLES - 1));
    assign cfg_err    = err_q;
`else
    assign cfg_err = 1'b0;
`endif

    // Reader FSM: two four-phase reads, then commit both values at once.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rd_state_q <= RD_IDLE;
            r_en_q     <= 1'b0;
            r_addr_q   <= 2'd0;
            busy_q     <= 1'b0;
            pending_q  <= 1'b0;
            tmp_r_q    <= 3'(DEF_R_WAIT);
            tmp_g_q    <= 3'(DEF_G_WAIT);
            r_wait_q   <= 3'(DEF_R_WAIT);
            g_wait_q   <= 3'(DEF_G_WAIT);
`ifdef TL_RD_TIMEOUT_EN
            wait_q     <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            if (new_cfg && rd_state_q != RD_IDLE) begin
                pending_q <= 1'b1;
            end
`ifdef TL_RD_TIMEOUT_EN
            // Counter runs in handshake states; every transition below clears it.
            wait_q <= rd_waiting ? wait_q + 1'b1 : '0;
`endif
            case (rd_state_q)
                RD_IDLE: begin
                    if (new_cfg) begin
                        rd_state_q <= RD_REQ0;
                        r_en_q     <= 1'b1;
                        r_addr_q   <= 2'd0;
                        busy_q     <= 1'b1;
                    end
                end
                RD_REQ0: begin
                    if (ack_s2_q) begin
                        tmp_r_q    <= r_data;
                        rd_state_q <= RD_REL0;
                        r_en_q     <= 1'b0;
`ifdef TL_RD_TIMEOUT_EN
                        wait_q     <= '0;
`endif
                    end
                end
                RD_REL0: begin
                    if (!ack_s2_q) begin
                        rd_state_q <= RD_REQ1;
                        r_en_q     <= 1'b1;
                        r_addr_q   <= 2'd1;
`ifdef TL_RD_TIMEOUT_EN
                        wait_q     <= '0;
`endif
                    end
                end
                RD_REQ1: begin
                    if (ack_s2_q) begin
                        tmp_g_q    <= r_data;
                        rd_state_q <= RD_REL1;
                        r_en_q     <= 1'b0;
`ifdef TL_RD_TIMEOUT_EN
                        wait_q     <= '0;
`endif
                    end
                end
                RD_REL1: begin
                    if (!ack_s2_q) begin
                        rd_state_q <= RD_COMMIT;
                    end
                end
                RD_COMMIT: begin
                    r_wait_q  <= tmp_r_q;
                    g_wait_q  <= tmp_g_q;
                    pending_q <= 1'b0;
`ifdef TL_RD_TIMEOUT_EN
                    err_q     <= 1'b0;
`endif
                    // A trigger landing in this very cycle is folded into the re-read.
                    if (pending_q || new_cfg) begin
                        rd_state_q <= RD_REQ0;
                        r_en_q     <= 1'b1;
                        r_addr_q   <= 2'd0;
                    end else begin
                        rd_state_q <= RD_IDLE;
                        busy_q     <= 1'b0;
                    end
                end
                default: begin
                    rd_state_q <= RD_IDLE;
                    r_en_q     <= 1'b0;
                    busy_q     <= 1'b0;
                end
            endcase
`ifdef TL_RD_TIMEOUT_EN
            if (timeout) begin
                rd_state_q <= RD_IDLE;
                r_en_q     <= 1'b0;
                busy_q     <= 1'b0;
                pending_q  <= 1'b0;
                err_q      <= 1'b1;
                wait_q     <= '0;
            end
`endif
        end
    end

    assign tick       = (tick_cnt_q == TW'(TICK_DIV - 1));
    assign tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;

    // Free-running tick prescaler.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
        end
    end

    // Light sequencer: durations are sampled from the shadows on phase entry.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            lt_state_q <= LT_RED;
            lt_cnt_q   <= phase_len(3'(DEF_R_WAIT));
            lamp_r_q   <= 1'b1;
            lamp_y_q   <= 1'b0;
            lamp_g_q   <= 1'b0;
        end else if (tick) begin
            if (lt_cnt_q <= 3'd1) begin
                case (lt_state_q)
                    LT_RED: begin
                        lt_state_q <= LT_GREEN;
                        lt_cnt_q   <= phase_len(g_wait_q);
                        lamp_r_q   <= 1'b0;
                        lamp_y_q   <= 1'b0;
                        lamp_g_q   <= 1'b1;
                    end
                    LT_GREEN: begin
                        lt_state_q <= LT_YELLOW;
                        lt_cnt_q   <= phase_len(3'(Y_WAIT));
                        lamp_r_q   <= 1'b0;
                        lamp_y_q   <= 1'b1;
                        lamp_g_q   <= 1'b0;
                    end
                    default: begin
                        lt_state_q <= LT_RED;
                        lt_cnt_q   <= phase_len(r_wait_q);
                        lamp_r_q   <= 1'b1;
                        lamp_y_q   <= 1'b0;
                        lamp_g_q   <= 1'b0;
                    end
                endcase
            end else begin
                lt_cnt_q <= lt_cnt_q - 3'd1;
            end
        end
    end

    assign done_sync2 = done_s2_q;
    assign r_en       = r_en_q;
    assign r_addr     = r_addr_q;
    assign cfg_busy   = busy_q;
    assign light_r    = lamp_r_q;
    assign light_y    = lamp_y_q;
    assign light_g    = lamp_g_q;

endmodule

// File: tb/tb_tl_cfg_reader.sv
// Bench for tl_cfg_reader: slave model, request-address scoreboard and a
// lamp-phase monitor fed by an event-level model of the committed timing.
module tb_tl_cfg_reader;

    localparam int TICK = 4;
    localparam int TOC  = 16;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       done = 1'b0;
    logic       ren_ack = 1'b0;
    logic [2:0] r_data = 3'd0;
    logic       done_sync2, r_en, light_r, light_y, light_g, cfg_busy, cfg_err;
    logic [1:0] r_addr;

    always #5 clk = ~clk;

    tl_cfg_reader #(
        .TICK_DIV  (TICK),
        .Y_WAIT    (2),
        .DEF_R_WAIT(3),
        .DEF_G_WAIT(3),
        .TO_CYCLES (TOC)
    ) dut (
        .clk       (clk),
        .n_rst     (n_rst),
        .done      (done),
        .done_sync2(done_sync2),
        .r_en      (r_en),
        .r_addr    (r_addr),
        .r_data    (r_data),
        .ren_ack   (ren_ack),
        .light_r   (light_r),
        .light_y   (light_y),
        .light_g   (light_g),
        .cfg_busy  (cfg_busy),
        .cfg_err   (cfg_err)
    );

    int checks = 0;
    int failures = 0;

    int         addr_q[$];
    logic [2:0] mem[2];
    int         slave_lat = 3;
    bit         slave_en = 1'b1;
    int         exp_r = 3, exp_g = 3;
    bit         expect_commit = 1'b1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int dur(input int v);
        return (v == 0) ? 1 : v;
    endfunction

    function automatic logic [2:0] next_lamp(input logic [2:0] l);
        case (l)
            3'b100:  return 3'b010;
            3'b010:  return 3'b001;
            default: return 3'b100;
        endcase
    endfunction

    // Slave: present data lat-1 clocks after seeing r_en, ack one clock later,
    // release ack lat clocks after r_en drops.
    initial forever begin
        int a;
        @(negedge clk);
        if (slave_en && r_en && !ren_ack) begin
            a = int'(r_addr);
            repeat (slave_lat - 1) @(negedge clk);
            r_data = mem[a];
            @(negedge clk);
            ren_ack = 1'b1;
            while (r_en) @(negedge clk);
            repeat (slave_lat) @(negedge clk);
            ren_ack = 1'b0;
        end
    end

    // Monitor: request scoreboard and lamp-phase length checks.
    logic       prev_ren = 1'b0;
    logic [1:0] hold_addr = 2'd0;
    logic [2:0] prev_lamp = 3'b100;
    logic [2:0] lamp;
    int         plen = 0, pexp = 0;
    bit         pvalid = 1'b0, mon_init = 1'b0, busy_prev = 1'b0;
    int         model_r = 3, model_g = 3;

    initial forever begin
        @(negedge clk);
        if (!n_rst) begin
            mon_init  = 1'b0;
            model_r   = 3;
            model_g   = 3;
            prev_ren  = 1'b0;
            busy_prev = 1'b0;
        end else begin
            if (r_en && !prev_ren) begin
                if (addr_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_r_en: r_addr=%0d, no request expected (t=%0t)", r_addr, $time);
                end else begin
                    check("r_addr", int'(r_addr), addr_q.pop_front());
                end
                hold_addr = r_addr;
            end else if (!r_en && prev_ren) begin
                check("r_addr_hold", int'(r_addr), int'(hold_addr));
            end
            prev_ren = r_en;

            lamp = {light_r, light_g, light_y};
            check("one_hot", $countones(lamp), 1);
            if (!mon_init) begin
                prev_lamp = lamp;
                plen      = 1;
                pvalid    = 1'b0;
                mon_init  = 1'b1;
            end else if (lamp != prev_lamp) begin
                check("lamp_order", int'(lamp), int'(next_lamp(prev_lamp)));
                if (pvalid) check($sformatf("phase_len_%b", prev_lamp), plen, pexp);
                pvalid    = !(cfg_busy || busy_prev);
                pexp      = TICK * ((lamp == 3'b100) ? dur(model_r) :
                                    (lamp == 3'b010) ? dur(model_g) : 2);
                prev_lamp = lamp;
                plen      = 1;
            end else begin
                plen++;
            end
            if (busy_prev && !cfg_busy && expect_commit) begin
                model_r = exp_r;
                model_g = exp_g;
            end
            busy_prev = cfg_busy;
        end
    end

    function automatic logic sig(input int w);
        case (w)
            0:       return cfg_busy;
            1:       return done_sync2;
            2:       return r_en && (r_addr == 2'd1);
            default: return r_en;
        endcase
    endfunction

    task automatic wait_cond(input int w, input logic lvl, input int bound, input string nm);
        int n = 0;
        while (sig(w) !== lvl && n < bound) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (sig(w) !== lvl) begin
            checks++;
            failures++;
            $display("FAIL %s: gave up after %0d cycles waiting for level %0d", nm, n, lvl);
        end
    endtask

    task automatic run_cfg(input int r, input int g, input int lat, input bit retrig, input bit lat_check);
        mem[0] = 3'(r);
        mem[1] = 3'(g);
        slave_lat = lat;
        exp_r = r;
        exp_g = g;
        expect_commit = 1'b1;
        addr_q.push_back(0);
        addr_q.push_back(1);
        @(posedge clk);
        #1 done = 1'b1;
        if (lat_check) begin
            @(posedge clk); #1;
            check("done_sync2_c1", done_sync2, 0);
            @(posedge clk); #1;
            check("done_sync2_c2", done_sync2, 1);
            check("r_en_c2", r_en, 0);
            @(posedge clk); #1;
            check("r_en_c3", r_en, 1);
            check("r_addr_c3", int'(r_addr), 0);
            check("cfg_busy_c3", cfg_busy, 1);
        end
        wait_cond(1, 1'b1, 20, "done_sync2_rise");
        done = 1'b0;
        if (retrig) begin
            wait_cond(2, 1'b1, 100, "req1_entry");
            addr_q.push_back(0);
            addr_q.push_back(1);
            done = 1'b1;
            wait_cond(1, 1'b1, 20, "done_sync2_retrig");
            done = 1'b0;
        end
        wait_cond(0, 1'b1, 20, "busy_rise");
        wait_cond(0, 1'b0, 2000, "busy_fall");
        check("cfg_err_after_commit", cfg_err, 0);
        check("requests_drained", addr_q.size(), 0);
        repeat (170) @(posedge clk);
    endtask

    initial begin
        mem[0] = 3'd3;
        mem[1] = 3'd3;
        repeat (2) @(posedge clk);
        #1;
        check("rst_r_en", r_en, 0);
        check("rst_r_addr", int'(r_addr), 0);
        check("rst_done_sync2", done_sync2, 0);
        check("rst_cfg_busy", cfg_busy, 0);
        check("rst_cfg_err", cfg_err, 0);
        check("rst_lamps", int'({light_r, light_g, light_y}), 4);
        @(negedge clk);
        n_rst = 1'b1;

        repeat (110) @(posedge clk);
        #1;
        check("idle_r_en", r_en, 0);
        check("idle_cfg_busy", cfg_busy, 0);

        run_cfg(5, 2, 3, 1'b0, 1'b1);
        run_cfg(0, 0, 3, 1'b0, 1'b0);
        run_cfg(4, 6, 3, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            run_cfg(int'($urandom_range(7, 0)), int'($urandom_range(7, 0)),
                    int'($urandom_range(5, 1)), ($urandom_range(3, 0) == 0), 1'b0);
        end

        // Slave goes silent: request must either time out or hang.
        slave_en = 1'b0;
        expect_commit = 1'b0;
        addr_q.push_back(0);
        @(posedge clk);
        #1 done = 1'b1;
        wait_cond(3, 1'b1, 20, "req0_silent");
`ifdef TL_RD_TIMEOUT_EN
        begin
            int n = 0;
            while (r_en && n < 100) begin
                @(posedge clk);
                #1;
                n++;
            end
            check("timeout_cycles", n, TOC);
        end
        check("cfg_err_set", cfg_err, 1);
        check("busy_after_timeout", cfg_busy, 0);
        repeat (100) @(posedge clk);
        done = 1'b0;
        repeat (6) @(posedge clk);
        addr_q.push_back(0);
        #1 done = 1'b1;
        wait_cond(3, 1'b1, 20, "req0_rearm");
`else
        repeat (40) @(posedge clk);
        #1;
        check("r_en_hangs", r_en, 1);
        check("busy_hangs", cfg_busy, 1);
        check("cfg_err_tied", cfg_err, 0);
`endif

        // Reset mid-read: outputs drop at once, done still high re-triggers.
        @(posedge clk);
        #2 n_rst = 1'b0;
        #1;
        check("arst_r_en", r_en, 0);
        check("arst_cfg_busy", cfg_busy, 0);
        check("arst_cfg_err", cfg_err, 0);
        check("arst_done_sync2", done_sync2, 0);
        check("arst_light_r", light_r, 1);
        repeat (2) @(posedge clk);
        exp_r = int'(mem[0]);
        exp_g = int'(mem[1]);
        expect_commit = 1'b1;
        slave_en = 1'b1;
        addr_q.push_back(0);
        addr_q.push_back(1);
        #2 n_rst = 1'b1;
        wait_cond(1, 1'b1, 20, "resync_done");
        done = 1'b0;
        wait_cond(0, 1'b1, 20, "busy_rise_after_rst");
        wait_cond(0, 1'b0, 2000, "busy_fall_after_rst");
        check("requests_drained_final", addr_q.size(), 0);
        repeat (170) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
